// File: rtl/multdiv_issue_ctrl_pkg.sv
`default_nettype none
// ==== multdiv_issue_ctrl_pkg : shared FSM encoding and writeback constants ====
// ==== rev 1.0                                                              ====
package multdiv_issue_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0]  DEF_RSTATUS_REG   = 5'd30;
  localparam logic [31:0] DEF_MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DEF_DIV_EXC_CODE  = 32'd5;

endpackage
`default_nettype wire

// File: rtl/multdiv_watchdog.sv
`default_nettype none
// ==== multdiv_watchdog : saturating cycle counter with terminal-count flag ====
// ==== rev 1.0                                                             ====
module multdiv_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != C_LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ==== multdiv_issue_ctrl : issues mult/div ops, stalls until ready, writes back ====
// ==== rev 1.0                                                                   ====
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int          TIMEOUT       = 40,
  parameter logic [4:0]  RSTATUS_REG   = DEF_RSTATUS_REG,
  parameter logic [31:0] MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE  = DEF_DIV_EXC_CODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_mult,
  input  logic        op_div,
  input  logic [4:0]  op_rd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  logic [1:0]  state_q, state_d;
  logic        is_mult_q, is_mult_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        mult_pulse_q, mult_pulse_d;
  logic        div_pulse_q, div_pulse_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        accept;
  logic        timed_out;
  logic [31:0] exc_code;

  assign accept   = (state_q == ST_IDLE) && (op_mult || op_div);
  assign exc_code = is_mult_q ? MULT_EXC_CODE : DIV_EXC_CODE;

  multdiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .enable   (state_q == ST_BUSY),
    .terminal (timed_out)
  );

  always_comb begin
    state_d      = state_q;
    is_mult_d    = is_mult_q;
    rd_d         = rd_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    mult_pulse_d = 1'b0;
    div_pulse_d  = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Mult has priority when both requests arrive together.
          is_mult_d    = op_mult;
          rd_d         = op_rd;
          opa_d        = op_a;
          opb_d        = op_b;
          mult_pulse_d = op_mult;
          div_pulse_d  = !op_mult;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (data_resultRDY) begin
          wb_rd_d   = data_exception ? RSTATUS_REG : rd_q;
          wb_data_d = data_exception ? exc_code : data_result;
          state_d   = ST_DONE;
        end else if (timed_out) begin
          wb_rd_d   = RSTATUS_REG;
          wb_data_d = exc_code;
          state_d   = ST_DONE;
        end
      end
      // DONE is the release cycle of the same instruction, so requests are not accepted.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_mult_q    <= 1'b0;
      rd_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      mult_pulse_q <= 1'b0;
      div_pulse_q  <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      is_mult_q    <= is_mult_d;
      rd_q         <= rd_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      mult_pulse_q <= mult_pulse_d;
      div_pulse_q  <= div_pulse_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign ctrl_MULT     = mult_pulse_q;
  assign ctrl_DIV      = div_pulse_q;
  assign data_operandA = opa_q;
  assign data_operandB = opb_q;
  assign stall         = accept || (state_q == ST_BUSY);
  assign wb_valid      = (state_q == ST_DONE);
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ==== tb_multdiv_issue_ctrl : scoreboard bench for the mult/div issue controller ====
// ==== rev 1.0                                                                    ====
module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_mult, op_div;
  logic [4:0]  op_rd;
  logic [31:0] op_a, op_b;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  multdiv_issue_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .op_mult        (op_mult),
    .op_div         (op_div),
    .op_rd          (op_rd),
    .op_a           (op_a),
    .op_b           (op_b),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data)
  );

  // One full op. Inputs change at the falling edge, outputs are sampled 1ns later.
  // delay > 0: ready raised in cycle T+delay; delay < 0: never ready (timeout).
  task automatic do_op(input string name, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input int delay, input logic [31:0] result, input logic exc,
                       input logic hold);
    wb_t e, got;
    int  done_k;
    logic bad;
    if (exc || delay < 0) begin
      e.rd   = 5'd30;
      e.data = m ? 32'd4 : 32'd5;
    end else begin
      e.rd   = rd;
      e.data = result;
    end
    exp_q.push_back(e);
    done_k = (delay > 0) ? delay + 1 : TIMEOUT + 2;

    @(negedge clk);
    op_mult = m; op_div = d; op_a = a; op_b = b; op_rd = rd;
    #1;
    checks++;
    if (stall !== 1'b1 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: stall=%b ctrl_MULT=%b ctrl_DIV=%b required stall=1 ctrl=0/0",
               name, stall, ctrl_MULT, ctrl_DIV);
    end

    @(negedge clk);
    if (!hold) begin
      op_mult = 1'b0; op_div = 1'b0; op_a = ~a; op_b = ~b; op_rd = ~rd;
    end
    #1;
    checks++;
    if (ctrl_MULT !== m || ctrl_DIV !== (d && !m) || stall !== 1'b1 ||
        data_operandA !== a || data_operandB !== b) begin
      errors++;
      $display("FAIL %s_issue: ctrl_MULT=%b ctrl_DIV=%b stall=%b A=%h B=%h required %b %b 1 %h %h",
               name, ctrl_MULT, ctrl_DIV, stall, data_operandA, data_operandB,
               m, d && !m, a, b);
    end

    bad = 1'b0;
    for (int k = 2; k < done_k; k++) begin
      @(negedge clk);
      data_resultRDY = (k == delay);
      data_exception = (k == delay) && exc;
      data_result    = (k == delay) ? result : 32'hdead_beef;
      #1;
      if (ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0 ||
          data_operandA !== a || data_operandB !== b)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_busy: pulse/stall/operand/wb_valid deviated during busy, required steady busy",
               name);
    end

    @(negedge clk);
    data_resultRDY = 1'b0; data_exception = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_cycle: wb_valid=%b stall=%b at cycle T+%0d required 1 0",
               name, wb_valid, stall, done_k);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue empty at writeback", name);
    end else begin
      got = exp_q.pop_front();
      if (wb_rd !== got.rd || wb_data !== got.data) begin
        errors++;
        $display("FAIL %s_wb: rd=%0d data=%h required rd=%0d data=%h",
                 name, wb_rd, wb_data, got.rd, got.data);
      end
    end

    if (!hold) begin
      @(negedge clk);
      #1;
      checks++;
      if (wb_valid !== 1'b0 || stall !== 1'b0 || wb_rd !== e.rd || wb_data !== e.data ||
          ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
        errors++;
        $display("FAIL %s_after: wb_valid=%b stall=%b rd=%0d data=%h required 0 0 %0d %h (held)",
                 name, wb_valid, stall, wb_rd, wb_data, e.rd, e.data);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op_mult = 0; op_div = 0; op_rd = 0; op_a = 0; op_b = 0;
    data_result = 0; data_exception = 0; data_resultRDY = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ctrl_MULT, ctrl_DIV, stall, wb_valid} !== 4'b0 || data_operandA !== 0 ||
        data_operandB !== 0 || wb_rd !== 0 || wb_data !== 0) begin
      errors++;
      $display("FAIL reset_state: ctrl=%b%b stall=%b wb_valid=%b A=%h B=%h rd=%0d data=%h required all 0",
               ctrl_MULT, ctrl_DIV, stall, wb_valid, data_operandA, data_operandB, wb_rd, wb_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    do_op("mult", 1'b1, 1'b0, 32'd6, 32'd7, 5'd3, 33, 32'd42, 1'b0, 1'b0);
  endtask

  task automatic test_exceptions();
    do_op("div_by_zero", 1'b0, 1'b1, 32'd10, 32'd0, 5'd12, 20, 32'd0, 1'b1, 1'b0);
    do_op("mult_exc", 1'b1, 1'b0, 32'h8000_0000, 32'hffff_ffff, 5'd8, 25, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    do_op("timeout", 1'b0, 1'b1, 32'd100, 32'd3, 5'd17, -1, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_first", 1'b1, 1'b0, 32'd10, 32'd10, 5'd4, 8, 32'd100, 1'b0, 1'b1);
    do_op("b2b_second", 1'b1, 1'b0, 32'd3, 32'd4, 5'd9, 12, 32'd12, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    bad_block : begin
      logic bad;
      @(negedge clk);
      op_mult = 1'b1; op_a = 32'd9; op_b = 32'd11; op_rd = 5'd7;
      @(negedge clk);
      op_mult = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({ctrl_MULT, ctrl_DIV, stall, wb_valid} !== 4'b0 || data_operandA !== 0 ||
          data_operandB !== 0 || wb_rd !== 0 || wb_data !== 0) begin
        errors++;
        $display("FAIL reset_mid_busy: ctrl=%b%b stall=%b wb_valid=%b A=%h B=%h rd=%0d data=%h required all 0",
                 ctrl_MULT, ctrl_DIV, stall, wb_valid, data_operandA, data_operandB, wb_rd, wb_data);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (22) @(negedge clk);
      data_resultRDY = 1'b1; data_result = 32'd123;
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL late_ready_stall: stall=%b required 0", stall);
      end
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        data_resultRDY = 1'b0;
        #1;
        if (wb_valid !== 1'b0 || stall !== 1'b0 || ctrl_MULT !== 1'b0 || wb_rd !== 0 || wb_data !== 0)
          bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL late_ready_ignored: writeback or activity after reset, required idle with zero outputs");
      end
    end
  endtask

  task automatic test_spurious_and_both();
    @(negedge clk);
    data_resultRDY = 1'b1; data_result = 32'd77;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ready_same: wb_valid=%b stall=%b required 0 0", wb_valid, stall);
    end
    @(negedge clk);
    data_resultRDY = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ready_next: wb_valid=%b ctrl=%b%b required 0 00", wb_valid, ctrl_MULT, ctrl_DIV);
    end
    do_op("mult_div_both", 1'b1, 1'b1, 32'd5, 32'd2, 5'd21, 10, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_exceptions();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    test_spurious_and_both();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d writebacks outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
`default_nettype wire

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
Processor-side initiator for the iterative mult/div unit. It accepts a mult/div instruction from the DX stage and issues a one-cycle ctrl_MULT/ctrl_DIV start pulse with held operands. It stalls the pipeline until the unit's data_resultRDY returns, then presents a one-cycle writeback to the PW stage. A watchdog converts a missing ready into an rstatus exception.

Parameters:
TIMEOUT, 40, max cycles in BUSY before a forced exception completion (must exceed mult/div latency of 33).
RSTATUS_REG, 30, destination register for exception writeback.
MULT_EXC_CODE, 4, rstatus value on mult exception.
DIV_EXC_CODE, 5, rstatus value on div exception.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
op_mult  in  1  DX instruction is mult (valid this cycle)
op_div  in  1  DX instruction is div (valid this cycle)
op_rd  in  5  destination register of DX instruction
op_a  in  32  operand A from DX
op_b  in  32  operand B from DX
data_result  in  32  result from mult/div unit
data_exception  in  1  exception flag from unit, valid with data_resultRDY
data_resultRDY  in  1  unit result ready
ctrl_MULT  out  1  one-cycle mult start pulse
ctrl_DIV  out  1  one-cycle div start pulse
data_operandA  out  32  latched operand A, held for whole op
data_operandB  out  32  latched operand B, held for whole op
stall  out  1  freeze F/D/DX
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  32  writeback value

Behaviour:
- Clock clk, reset asynchronous active-high. On reset all outputs 0, state IDLE, counter 0, latched op type/rd/operands 0. Reset mid-BUSY abandons the op; late data_resultRDY after reset is ignored (state is IDLE).
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE, cycle T, op_mult|op_div=1: stall=1 combinationally in T. Edge T latches op_a, op_b, op_rd, and op type; state goes to BUSY; counter clears. ctrl_MULT or ctrl_DIV=1 in cycle T+1 only. If both op_mult and op_div are set, mult wins.
- BUSY: stall=1. Counter increments each cycle and saturates at TIMEOUT. The operand outputs do not change.
- BUSY, data_resultRDY=1, data_exception=0: at that edge wb_data=data_result and wb_rd=latched rd; go to DONE.
- BUSY, data_resultRDY=1, data_exception=1: wb_rd=RSTATUS_REG; wb_data=MULT_EXC_CODE or DIV_EXC_CODE per latched op type; go to DONE.
- BUSY, counter==TIMEOUT with no ready: same as the exception case; go to DONE.
- Ready and timeout in the same cycle: ready wins.
- DONE: wb_valid=1 for exactly this cycle and stall=0, so the stalled instruction advances at the end of DONE. op_mult/op_div seen in DONE are ignored because that is the same instruction. Next state is IDLE.
- data_resultRDY in IDLE or DONE is ignored.
- wb_rd and wb_data hold their values outside DONE. Only wb_valid qualifies them.
- Minimum spacing between back-to-back ops is the DONE cycle plus one IDLE acceptance cycle.

Decomposition:
- Shared package: state encoding constants, RSTATUS_REG, MULT_EXC_CODE, DIV_EXC_CODE.
- One natural sub-module: multdiv_watchdog, a saturating counter of width $clog2(TIMEOUT+1) with clear/enable and a terminal-count output.
- The FSM and latches stay in the top.

Test Plan:
- Mult issue: op_mult=1, op_a=6, op_b=7, op_rd=3 in IDLE; bench asserts data_resultRDY with data_result=42 after 33 cycles. Required: ctrl_MULT pulses exactly once at T+1; stall high from T through the ready edge; wb_valid one cycle with wb_rd=3, wb_data=42; stall low in DONE.
- Div by zero: op_div, op_a=10, op_b=0; ready with data_exception=1. Required: wb_rd=30, wb_data=5, wb_valid one cycle. Same sequence with op_mult and an exception gives wb_data=4.
- Timeout: issue div and never assert ready. Required: DONE reached exactly TIMEOUT+1 cycles after BUSY entry, with wb_rd=30 and wb_data=5.
- Back-to-back ops with op_mult held through DONE: no second ctrl_MULT from the DONE cycle. A new op presented in the following IDLE cycle issues normally with new operands.
- Reset asserted mid-BUSY (cycle 10), then data_resultRDY at cycle 33. Required: all outputs 0 immediately (asynchronous), no wb_valid, state stays IDLE.
- Spurious data_resultRDY in IDLE, and op_mult&op_div together. Required: no wb_valid from the spurious ready; only ctrl_MULT fires for the simultaneous request.
